// File: rtl/enc3b4b_if.sv
// Beat interface for the 3B/4B encoder: input beat (k, x, y, rd) and encoded
// output beat (code, rd, s, kerr), each side with its own valid/ready pair.
interface enc3b4b_if #(
  parameter int LANES = 1
);
  // A beat moves on a rising clk edge where valid & ready are both high;
  // a producer holds valid and its data unchanged until that edge.
  logic               in_valid;
  logic               in_ready;
  logic [LANES-1:0]   in_k;
  logic [5*LANES-1:0] in_x;
  logic [3*LANES-1:0] in_y;
  logic [LANES-1:0]   in_rd;
  logic               out_valid;
  logic               out_ready;
  logic [4*LANES-1:0] out_code;
  logic [LANES-1:0]   out_rd;
  logic [LANES-1:0]   out_s;
  logic [LANES-1:0]   out_kerr;

  modport slave (
    input  in_valid, in_k, in_x, in_y, in_rd, out_ready,
    output in_ready, out_valid, out_code, out_rd, out_s, out_kerr
  );

  modport master (
    output in_valid, in_k, in_x, in_y, in_rd, out_ready,
    input  in_ready, out_valid, out_code, out_rd, out_s, out_kerr
  );
endinterface

// File: rtl/enc3b4b_pipe.sv
// Multi-lane pipelined 3B/4B sub-block encoder with valid/ready on both sides.
// Define ENC_KCHECK_EN to flag illegal K codes on out_kerr (otherwise tied 0).
module enc3b4b_pipe #(
  parameter int LANES       = 1,
  parameter int PIPE_STAGES = 1
) (
  input logic      clk,
  input logic      rst,
  enc3b4b_if.slave bus
);
  localparam int W = 7 * LANES;

  logic [4*LANES-1:0] enc_code;
  logic [LANES-1:0]   enc_rd;
  logic [LANES-1:0]   enc_s;
  logic [LANES-1:0]   enc_kerr;
  logic [W-1:0]       enc_word;

  always_comb begin
    logic [4:0] x;
    logic [2:0] y;
    logic       k;
    logic       rd;
    logic       s;
    logic [3:0] c;
    enc_code = '0;
    enc_rd   = '0;
    enc_s    = '0;
    enc_kerr = '0;
    for (int n = 0; n < LANES; n++) begin
      x  = bus.in_x[5*n +: 5];
      y  = bus.in_y[3*n +: 3];
      k  = bus.in_k[n];
      rd = bus.in_rd[n];
      s  = (k && y == 3'd7)
         || (!rd && (x == 5'd17 || x == 5'd18 || x == 5'd20))
         || ( rd && (x == 5'd11 || x == 5'd13 || x == 5'd14));
      // K codes only differ from D codes on the negative-RD side of y1/2/5/6
      c = 4'b0000;
      case (y)
        3'd0: c = rd ? 4'b0100 : 4'b1011;
        3'd1: c = (k && !rd) ? 4'b0110 : 4'b1001;
        3'd2: c = (k && !rd) ? 4'b1010 : 4'b0101;
        3'd3: c = rd ? 4'b0011 : 4'b1100;
        3'd4: c = rd ? 4'b0010 : 4'b1101;
        3'd5: c = (k && !rd) ? 4'b0101 : 4'b1010;
        3'd6: c = (k && !rd) ? 4'b1001 : 4'b0110;
        3'd7: c = s ? (rd ? 4'b1000 : 4'b0111) : (rd ? 4'b0001 : 4'b1110);
        default: c = 4'b0000;
      endcase
      enc_code[4*n +: 4] = c;
      enc_s[n]  = s;
      enc_rd[n] = rd ^ (y == 3'd0 || y == 3'd4 || y == 3'd7);
`ifdef ENC_KCHECK_EN
      enc_kerr[n] = k && !(x == 5'd28 ||
                           (y == 3'd7 && (x == 5'd23 || x == 5'd27 ||
                                          x == 5'd29 || x == 5'd30)));
`endif
    end
  end

  assign enc_word = {enc_kerr, enc_s, enc_rd, enc_code};

  logic [PIPE_STAGES-1:0] vld;
  logic [PIPE_STAGES-1:0] ld;
  logic [PIPE_STAGES-1:0] src_v;
  logic [W-1:0]           data [PIPE_STAGES];
  logic [W-1:0]           src  [PIPE_STAGES];
  logic [W-1:0]           last;

  always_comb begin
    src[0]   = enc_word;
    src_v[0] = bus.in_valid;
    for (int i = 1; i < PIPE_STAGES; i++) begin
      src[i]   = data[i-1];
      src_v[i] = vld[i-1];
    end
  end

  // Stage i may load if it or any stage after it is empty, or the sink takes.
  always_comb begin
    logic t;
    ld = '0;
    for (int i = 0; i < PIPE_STAGES; i++) begin
      t = bus.out_ready;
      for (int j = i; j < PIPE_STAGES; j++) t = t | ~vld[j];
      ld[i] = t;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) data[i] <= '0;
    end else begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        if (ld[i]) begin
          vld[i] <= src_v[i];
          if (src_v[i]) data[i] <= src[i];
        end
      end
    end
  end

  assign last          = data[PIPE_STAGES-1];
  assign bus.in_ready  = ld[0];
  assign bus.out_valid = vld[PIPE_STAGES-1];
  assign bus.out_code  = last[4*LANES-1:0];
  assign bus.out_rd    = last[5*LANES-1:4*LANES];
  assign bus.out_s     = last[6*LANES-1:5*LANES];
  assign bus.out_kerr  = last[7*LANES-1:6*LANES];
endmodule

// File: tb/tb_enc3b4b_pipe.sv
// Bench for enc3b4b_pipe: table-driven reference model, expected-value queue,
// and a monitor that checks every delivered beat and the in_ready backpressure.
module tb_enc3b4b_pipe;
  localparam int L  = 4;
  localparam int P  = 2;
  localparam int W  = 7 * L;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  enc3b4b_if #(.LANES(L)) bus ();

  enc3b4b_pipe #(.LANES(L), .PIPE_STAGES(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int occ         = 0;
  logic rand_ready = 1'b0;
  logic [W-1:0] exp_q[$];

  // Code tables written straight from the 3B/4B table: [rd][y]
  logic [3:0] dtab [2][8] = '{'{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110},
                              '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001}};
  logic [3:0] ktab [2][8] = '{'{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b1110},
                              '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001}};
  logic [3:0] alt7 [2]    = '{4'b0111, 4'b1000};

  function automatic logic [W-1:0] model(input logic [L-1:0] k, input logic [5*L-1:0] x,
                                         input logic [3*L-1:0] y, input logic [L-1:0] rd);
    logic [4*L-1:0] code = '0;
    logic [L-1:0] ro = '0, so = '0, ke = '0;
    for (int n = 0; n < L; n++) begin
      int xi = int'(x[5*n +: 5]);
      int yi = int'(y[3*n +: 3]);
      int ri = int'(rd[n]);
      logic s;
      logic [3:0] c;
      s = (k[n] && yi == 7) || (ri == 0 && xi inside {17, 18, 20}) ||
          (ri == 1 && xi inside {11, 13, 14});
      if (yi == 7 && s) c = alt7[ri];
      else if (k[n])    c = ktab[ri][yi];
      else              c = dtab[ri][yi];
      code[4*n +: 4] = c;
      so[n] = s;
      ro[n] = rd[n] ^ ($countones(c) != 2);
`ifdef ENC_KCHECK_EN
      ke[n] = k[n] && !(xi == 28 || (yi == 7 && xi inside {23, 27, 29, 30}));
`endif
    end
    return {ke, so, ro, code};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: backpressure rule and scoreboard pop on every delivered beat
  always @(negedge clk) begin
    if (rst) begin
      occ = 0;
    end else begin
      check("in_ready", W'(bus.in_ready), W'((occ < P) || bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", W'(1), W'(0));
        end else begin
          check("beat", {bus.out_kerr, bus.out_s, bus.out_rd, bus.out_code}, exp_q.pop_front());
        end
      end
      occ = occ + int'(bus.in_valid && bus.in_ready) - int'(bus.out_valid && bus.out_ready);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Driver: call just after a posedge; returns just after the accepting edge
  task automatic send_beat(input logic [L-1:0] k, input logic [5*L-1:0] x,
                           input logic [3*L-1:0] y, input logic [L-1:0] rd);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_k = k; bus.in_x = x; bus.in_y = y; bus.in_rd = rd;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waited++;
      if (waited > 200) break;
    end
    if (waited > 200) check("accept_timeout", W'(0), W'(1));
    else exp_q.push_back(model(k, x, y, rd));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_random();
    send_beat(L'($urandom), (5*L)'($urandom), (3*L)'($urandom), L'($urandom));
  endtask

  task automatic send_lane0(input logic k, input logic [4:0] x, input logic [2:0] y, input logic rd);
    logic [L-1:0] kv = L'($urandom);
    logic [5*L-1:0] xv = (5*L)'($urandom);
    logic [3*L-1:0] yv = (3*L)'($urandom);
    logic [L-1:0] rv = L'($urandom);
    kv[0] = k; xv[4:0] = x; yv[2:0] = y; rv[0] = rd;
    send_beat(kv, xv, yv, rv);
  endtask

  task automatic drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 500) begin
      @(posedge clk); c++;
    end
    #1;
    check("drain", W'(exp_q.size()), W'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.in_k = '0; bus.in_x = '0; bus.in_y = '0; bus.in_rd = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {bus.out_kerr, bus.out_s, bus.out_rd, bus.out_code}, W'(0));
    check("reset_out_valid", W'(bus.out_valid), W'(0));
    check("reset_in_ready", W'(bus.in_ready), W'(1));
    @(posedge clk); #1;

    // Directed lane-0 cases; other lanes random
    send_lane0(1'b0, 5'd0,  3'd0, 1'b1);
    send_lane0(1'b0, 5'd17, 3'd7, 1'b0);
    send_lane0(1'b0, 5'd17, 3'd7, 1'b1);
    send_lane0(1'b1, 5'd28, 3'd1, 1'b1);
    send_lane0(1'b1, 5'd28, 3'd7, 1'b0);
    send_lane0(1'b1, 5'd5,  3'd1, 1'b0);
    send_lane0(1'b1, 5'd28, 3'd5, 1'b1);
    send_lane0(1'b1, 5'd23, 3'd7, 1'b0);
    send_lane0(1'b0, 5'd11, 3'd7, 1'b1);
    for (int i = 0; i < 16; i++) send_lane0(1'b1, 5'd28, 3'(i), 1'(i >> 3));
    drain();

    // Back-to-back burst with the sink stalled for four clocks
    fork
      for (int i = 0; i < 10; i++) send_random();
      begin
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats held in flight
    bus.out_ready = 1'b0;
    send_random();
    send_random();
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_out_valid", W'(bus.out_valid), W'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", W'(bus.out_valid), W'(0));
    @(posedge clk); #1;
    send_random();
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!bus.out_valid && n < 20);
    check("latency", W'(n), W'(P));
    drain();

    // Random traffic under random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
      send_random();
    end
    drain();
    rand_ready = 1'b0;
    @(posedge clk); #1 bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
